multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Main control state machine for the multi-cycle RV32I core. It sequences the shared ALU, the unified instruction/data memory port, the register file and the PC/IR/ALUOut/Data registers using the opcode from the instruction decoder. It also handles memory wait states and illegal opcodes. It sits beside the instruction decoder and drives all datapath mux selects and write enables.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  core clock, rising-edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `opcode`  in  7 (`opcode_t`)  decoded opcode; stable from DECODE until the next FETCH
- `branch_cond`  in  1  branch comparison result for the current funct3; valid in BRANCH
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access request
- `mem_write`  out  1  store strobe
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `ir_write`  out  1  load IR and OldPC
- `pc_update`  out  1  load PC from Result
- `reg_write`  out  1  register file write enable
- `alu_src_a`  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1 register, 11 zero
- `alu_src_b`  out  2  ALU B select: 00 rs2 register, 01 imm_ext, 10 constant 4
- `result_src`  out  2  Result select: 00 ALUOut, 01 Data, 10 ALU result (direct)
- `alu_op`  out  (`alu_op_t`)  drives the ALU decoder
- `illegal_instr`  out  1  high while in TRAP
- `instr_retired`  out  1  one-cycle pulse on the cycle whose next state is FETCH from a non-FETCH state
- `state`  out  4  current state, for debug and the testbench

## Operation
Unlisted outputs are 0. The `alu_op` default is ALU_OP__UNSET.

- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=ADD, result_src=10.
  - ir_write and pc_update are both set to mem_ready.
  - Next state: DECODE if mem_ready, else stay in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=ADD. This precomputes the branch/JAL target into ALUOut.
  - Load or store: MEMADR.
  - RType: EXECR.
  - IType_logic: EXECI.
  - JType: JAL.
  - IType_jalr: JALR.
  - BType: BRANCH.
  - UType_lui or UType_auipc: UTYPE.
  - Any other opcode: TRAP.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=ADD. Next: MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req=1, adr_src=1. Next: MEMWB when mem_ready, else hold.
- MEMWB: result_src=01, reg_write=1. Next: FETCH.
- MEMWRITE: mem_req=1, adr_src=1, mem_write=1. Next: FETCH when mem_ready, else hold.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=REGISTER_OPERATION. Next: ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=REGISTER_OPERATION. Next: ALUWB.
- ALUWB: result_src=00, reg_write=1. Next: FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=BRANCH, result_src=00, pc_update=branch_cond. Next: FETCH.
- JAL: result_src=00, pc_update=1. Next: LINK.
- JALR: alu_src_a=10, alu_src_b=01, alu_op=ADD, result_src=10, pc_update=1. Next: LINK.
- LINK: alu_src_a=01, alu_src_b=10, alu_op=ADD, result_src=10, reg_write=1. This writes OldPC+4 to rd. Next: FETCH.
- UTYPE: alu_src_a = 11 for lui, 01 for auipc; alu_src_b=01, alu_op=ADD. Next: ALUWB.
- TRAP: illegal_instr=1, all enables 0. Remains in TRAP until reset.

## Timing
- Reset:
  - Asserting rst_n low forces state=FETCH immediately, even in mid-access.
  - While rst_n is low, every output enable (mem_req, mem_write, ir_write, pc_update, reg_write, illegal_instr, instr_retired) is 0.
  - The first access starts on the first rising edge after rst_n deasserts.
- Output style:
  - Outputs are Moore, decoded from `state`.
  - Exceptions: ir_write and pc_update in FETCH (gated by mem_ready) and pc_update in BRANCH (gated by branch_cond).
- Memory handshake:
  - mem_req stays high continuously until the cycle mem_ready=1; the access completes on that edge.
  - mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Latency with zero wait states:
  - Branch 3 cycles.
  - R, I, U-type 4 cycles.
  - Store 4, JAL 4, JALR 4 cycles.
  - Load 5 cycles.
  - Each wait cycle adds 1.
- JALR with rd == rs1: rs1 is consumed in JALR before LINK writes rd.
- instr_retired: fires exactly once per non-trapping instruction; never fires in TRAP.

## Structure
- Put `ctrl_state_t` (4-bit enum, FETCH = 0) in the shared types header.
- Put the `alu_src_a_t`, `alu_src_b_t` and `result_src_t` select enums there too, alongside the existing `opcode_t` and `alu_op_t`.
- Natural split:
  - State register plus next-state logic in `multicycle_control_fsm`.
  - Purely combinational output decode in sub-module `control_output_decoder` (inputs: state, opcode, mem_ready, branch_cond).

## Test plan
- Reset and first fetch: rst_n low, then high, with mem_ready=1 → state FETCH, ir_write=pc_update=1 on the first cycle, DECODE on the next cycle; all enables 0 while in reset.
- R-type add, opcode 0110011, mem_ready held 1 → FETCH, DECODE, EXECR, ALUWB; reg_write=1 only in ALUWB; instr_retired pulses once; 4 cycles.
- Load, opcode 0000011, mem_ready low for 2 cycles in MEMREAD → MEMREAD held 3 cycles with mem_req=1 and adr_src=1, then MEMWB with result_src=01 and reg_write=1.
- Branch, opcode 1100011:
  - branch_cond=1 → pc_update=1 in BRANCH.
  - branch_cond=0 → pc_update=0.
  - Both return to FETCH after 3 cycles.
- JALR, opcode 1100111 → JALR with pc_update=1 and result_src=10, then LINK with reg_write=1, alu_src_a=01, alu_src_b=10.
- Illegal opcode 0000000 → TRAP with illegal_instr=1 and no enables for 10 cycles; rst_n pulse returns to FETCH with illegal_instr=0.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types for the multi-cycle RV32I control path: opcodes, ALU control,
// datapath select encodings, FSM states and the decoded control word.
package multicycle_control_fsm_pkg;

  typedef enum logic [6:0] {
    OpLoad       = 7'b0000011,
    OpItypeLogic = 7'b0010011,
    OpAuipc      = 7'b0010111,
    OpStore      = 7'b0100011,
    OpRtype      = 7'b0110011,
    OpLui        = 7'b0110111,
    OpBtype      = 7'b1100011,
    OpJalr       = 7'b1100111,
    OpJtype      = 7'b1101111
  } opcode_t;

  typedef enum logic [1:0] {
    AluOpUnset  = 2'd0,
    AluOpAdd    = 2'd1,
    AluOpRegOp  = 2'd2,
    AluOpBranch = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    SrcAPc    = 2'b00,
    SrcAOldPc = 2'b01,
    SrcARs1   = 2'b10,
    SrcAZero  = 2'b11
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SrcBRs2  = 2'b00,
    SrcBImm  = 2'b01,
    SrcBFour = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ResAluOut    = 2'b00,
    ResData      = 2'b01,
    ResAluDirect = 2'b10
  } result_src_t;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StJalr     = 4'd11,
    StLink     = 4'd12,
    StUtype    = 4'd13,
    StTrap     = 4'd14
  } ctrl_state_t;

  typedef struct packed {
    logic        mem_req;
    logic        mem_write;
    logic        adr_src;
    logic        ir_write;
    logic        pc_update;
    logic        reg_write;
    alu_src_a_t  alu_src_a;
    alu_src_b_t  alu_src_b;
    result_src_t result_src;
    alu_op_t     alu_op;
    logic        illegal_instr;
  } ctrl_out_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the main FSM (master) and the datapath/decoder (slave).
interface multicycle_control_fsm_if;

  multicycle_control_fsm_pkg::opcode_t     opcode;
  logic                                    branch_cond;
  logic                                    mem_ready;
  logic                                    mem_req;
  logic                                    mem_write;
  logic                                    adr_src;
  logic                                    ir_write;
  logic                                    pc_update;
  logic                                    reg_write;
  multicycle_control_fsm_pkg::alu_src_a_t  alu_src_a;
  multicycle_control_fsm_pkg::alu_src_b_t  alu_src_b;
  multicycle_control_fsm_pkg::result_src_t result_src;
  multicycle_control_fsm_pkg::alu_op_t     alu_op;
  logic                                    illegal_instr;
  logic                                    instr_retired;
  multicycle_control_fsm_pkg::ctrl_state_t state;

  modport master (
    input  opcode, branch_cond, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_update, reg_write,
    output alu_src_a, alu_src_b, result_src, alu_op, illegal_instr, instr_retired, state
  );

  modport slave (
    output opcode, branch_cond, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_update, reg_write,
    input  alu_src_a, alu_src_b, result_src, alu_op, illegal_instr, instr_retired, state
  );

endinterface

// File: rtl/multicycle_control_fsm_control_output_decoder.sv
// Combinational control-word decode from the current FSM state. Moore except
// for the mem_ready gating in FETCH and the branch_cond gating in BRANCH.
module control_output_decoder
  import multicycle_control_fsm_pkg::*;
(
  input  ctrl_state_t state_i,
  input  opcode_t     opcode_i,
  input  logic        mem_ready_i,
  input  logic        branch_cond_i,
  output ctrl_out_t   out_o
);

  always_comb begin
    out_o = '0;
    unique case (state_i)
      StFetch: begin
        out_o.mem_req    = 1'b1;
        out_o.alu_src_b  = SrcBFour;
        out_o.alu_op     = AluOpAdd;
        out_o.result_src = ResAluDirect;
        out_o.ir_write   = mem_ready_i;
        out_o.pc_update  = mem_ready_i;
      end
      StDecode: begin
        // Precompute the branch/JAL target into ALUOut.
        out_o.alu_src_a = SrcAOldPc;
        out_o.alu_src_b = SrcBImm;
        out_o.alu_op    = AluOpAdd;
      end
      StMemAdr: begin
        out_o.alu_src_a = SrcARs1;
        out_o.alu_src_b = SrcBImm;
        out_o.alu_op    = AluOpAdd;
      end
      StMemRead: begin
        out_o.mem_req = 1'b1;
        out_o.adr_src = 1'b1;
      end
      StMemWb: begin
        out_o.result_src = ResData;
        out_o.reg_write  = 1'b1;
      end
      StMemWrite: begin
        out_o.mem_req   = 1'b1;
        out_o.adr_src   = 1'b1;
        out_o.mem_write = 1'b1;
      end
      StExecR: begin
        out_o.alu_src_a = SrcARs1;
        out_o.alu_src_b = SrcBRs2;
        out_o.alu_op    = AluOpRegOp;
      end
      StExecI: begin
        out_o.alu_src_a = SrcARs1;
        out_o.alu_src_b = SrcBImm;
        out_o.alu_op    = AluOpRegOp;
      end
      StAluWb: out_o.reg_write = 1'b1;
      StBranch: begin
        out_o.alu_src_a = SrcARs1;
        out_o.alu_src_b = SrcBRs2;
        out_o.alu_op    = AluOpBranch;
        out_o.pc_update = branch_cond_i;
      end
      StJal: out_o.pc_update = 1'b1;
      StJalr: begin
        // rs1 is consumed here, before LINK overwrites rd.
        out_o.alu_src_a  = SrcARs1;
        out_o.alu_src_b  = SrcBImm;
        out_o.alu_op     = AluOpAdd;
        out_o.result_src = ResAluDirect;
        out_o.pc_update  = 1'b1;
      end
      StLink: begin
        out_o.alu_src_a  = SrcAOldPc;
        out_o.alu_src_b  = SrcBFour;
        out_o.alu_op     = AluOpAdd;
        out_o.result_src = ResAluDirect;
        out_o.reg_write  = 1'b1;
      end
      StUtype: begin
        out_o.alu_src_a = (opcode_i == OpLui) ? SrcAZero : SrcAOldPc;
        out_o.alu_src_b = SrcBImm;
        out_o.alu_op    = AluOpAdd;
      end
      StTrap: out_o.illegal_instr = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multi-cycle RV32I core: state register, next-state
// logic and reset gating of the enables produced by the output decoder.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  multicycle_control_fsm_if.master        bus
);

  ctrl_state_t state_q, state_d;
  ctrl_out_t   dec;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItypeLogic:    state_d = StExecI;
          OpJtype:         state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpBtype:         state_d = StBranch;
          OpLui, OpAuipc:  state_d = StUtype;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = (bus.opcode == OpStore) ? StMemWrite : StMemRead;
      StMemRead:  if (bus.mem_ready) state_d = StMemWb;
      StMemWrite: if (bus.mem_ready) state_d = StFetch;
      StMemWb, StAluWb, StBranch, StLink: state_d = StFetch;
      StExecR, StExecI, StUtype:          state_d = StAluWb;
      StJal, StJalr:                      state_d = StLink;
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  control_output_decoder u_decoder (
    .state_i       (state_q),
    .opcode_i      (bus.opcode),
    .mem_ready_i   (bus.mem_ready),
    .branch_cond_i (bus.branch_cond),
    .out_o         (dec)
  );

  // Enables are forced low while reset is held, even though state reads FETCH.
  assign bus.mem_req       = dec.mem_req & rst_n;
  assign bus.mem_write     = dec.mem_write & rst_n;
  assign bus.ir_write      = dec.ir_write & rst_n;
  assign bus.pc_update     = dec.pc_update & rst_n;
  assign bus.reg_write     = dec.reg_write & rst_n;
  assign bus.illegal_instr = dec.illegal_instr & rst_n;
  assign bus.instr_retired = rst_n & (state_q != StFetch) & (state_d == StFetch);
  assign bus.adr_src       = dec.adr_src;
  assign bus.alu_src_a     = dec.alu_src_a;
  assign bus.alu_src_b     = dec.alu_src_b;
  assign bus.result_src    = dec.result_src;
  assign bus.alu_op        = dec.alu_op;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle control words,
// a negedge monitor pops and compares against the DUT.
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  typedef struct {
    logic [3:0] st;
    logic [7:0] en;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs;
    logic [1:0] aop;
    int         tag;
  } exp_t;

  // en bit order: mem_req mem_write adr_src ir_write pc_update reg_write illegal retired
  localparam logic [7:0] MREQ = 8'h80, MWR = 8'h40, ADR = 8'h20, IRW = 8'h10;
  localparam logic [7:0] PCU  = 8'h08, RW  = 8'h04, ILL = 8'h02, RET = 8'h01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] mon_en;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         tag_ctr = 0;

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e  = sb_q.pop_front();
      mon_en = {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write,
                bus.pc_update, bus.reg_write, bus.illegal_instr, bus.instr_retired};
      n_cmp++;
      if (bus.state !== mon_e.st || mon_en !== mon_e.en || bus.alu_src_a !== mon_e.a ||
          bus.alu_src_b !== mon_e.b || bus.result_src !== mon_e.rs ||
          bus.alu_op !== mon_e.aop) begin
        n_bad++;
        $display("FAIL ctrl_vec#%0d: got st=%0d en=%b a=%0d b=%0d rs=%0d op=%0d, want st=%0d en=%b a=%0d b=%0d rs=%0d op=%0d",
                 mon_e.tag, bus.state, mon_en, bus.alu_src_a, bus.alu_src_b, bus.result_src,
                 bus.alu_op, mon_e.st, mon_e.en, mon_e.a, mon_e.b, mon_e.rs, mon_e.aop);
      end
    end
  end

  task automatic push(input logic [3:0] st, input logic [7:0] en, input logic [1:0] a,
                      input logic [1:0] b, input logic [1:0] rs, input logic [1:0] aop);
    exp_t e;
    e.st = st; e.en = en; e.a = a; e.b = b; e.rs = rs; e.aop = aop; e.tag = tag_ctr;
    tag_ctr++;
    sb_q.push_back(e);
  endtask

  // Called #1 after a rising edge; expectation covers the cycle up to the next edge.
  task automatic step(input opcode_t opc, input logic rdy, input logic bc,
                      input logic [3:0] st, input logic [7:0] en, input logic [1:0] a,
                      input logic [1:0] b, input logic [1:0] rs, input logic [1:0] aop);
    bus.opcode      = opc;
    bus.mem_ready   = rdy;
    bus.branch_cond = bc;
    push(st, en, a, b, rs, aop);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input opcode_t opc, input logic rdy);
    step(opc, rdy, 1'b0, StFetch, rdy ? (MREQ | IRW | PCU) : MREQ,
         SrcAPc, SrcBFour, ResAluDirect, AluOpAdd);
  endtask

  task automatic decode(input opcode_t opc);
    step(opc, 1'b1, 1'b0, StDecode, 8'h00, SrcAOldPc, SrcBImm, ResAluOut, AluOpAdd);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    push(StFetch, 8'h00, SrcAPc, SrcBFour, ResAluDirect, AluOpAdd);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.opcode      = OpRtype;
    bus.mem_ready   = 1'b1;
    bus.branch_cond = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_pulse();

    // R-type add
    fetch(OpRtype, 1'b1);
    decode(OpRtype);
    step(OpRtype, 1'b1, 1'b0, StExecR, 8'h00, SrcARs1, SrcBRs2, ResAluOut, AluOpRegOp);
    step(OpRtype, 1'b1, 1'b0, StAluWb, RW | RET, SrcAPc, SrcBRs2, ResAluOut, AluOpUnset);

    // Load with one fetch wait and two MEMREAD waits
    fetch(OpLoad, 1'b0);
    fetch(OpLoad, 1'b1);
    decode(OpLoad);
    step(OpLoad, 1'b1, 1'b0, StMemAdr, 8'h00, SrcARs1, SrcBImm, ResAluOut, AluOpAdd);
    for (int i = 0; i < 3; i++) begin
      step(OpLoad, (i == 2), 1'b0, StMemRead, MREQ | ADR, SrcAPc, SrcBRs2, ResAluOut,
           AluOpUnset);
    end
    step(OpLoad, 1'b0, 1'b0, StMemWb, RW | RET, SrcAPc, SrcBRs2, ResData, AluOpUnset);

    // Store, zero wait
    fetch(OpStore, 1'b1);
    decode(OpStore);
    step(OpStore, 1'b1, 1'b0, StMemAdr, 8'h00, SrcARs1, SrcBImm, ResAluOut, AluOpAdd);
    step(OpStore, 1'b1, 1'b0, StMemWrite, MREQ | MWR | ADR | RET, SrcAPc, SrcBRs2, ResAluOut,
         AluOpUnset);

    // Branch taken then not taken
    for (int t = 1; t >= 0; t--) begin
      fetch(OpBtype, 1'b1);
      decode(OpBtype);
      step(OpBtype, 1'b1, t[0], StBranch, t[0] ? (PCU | RET) : RET, SrcARs1, SrcBRs2,
           ResAluOut, AluOpBranch);
    end

    // JAL
    fetch(OpJtype, 1'b1);
    decode(OpJtype);
    step(OpJtype, 1'b1, 1'b0, StJal, PCU, SrcAPc, SrcBRs2, ResAluOut, AluOpUnset);
    step(OpJtype, 1'b1, 1'b0, StLink, RW | RET, SrcAOldPc, SrcBFour, ResAluDirect, AluOpAdd);

    // JALR
    fetch(OpJalr, 1'b1);
    decode(OpJalr);
    step(OpJalr, 1'b1, 1'b0, StJalr, PCU, SrcARs1, SrcBImm, ResAluDirect, AluOpAdd);
    step(OpJalr, 1'b1, 1'b0, StLink, RW | RET, SrcAOldPc, SrcBFour, ResAluDirect, AluOpAdd);

    // I-type logic
    fetch(OpItypeLogic, 1'b1);
    decode(OpItypeLogic);
    step(OpItypeLogic, 1'b1, 1'b0, StExecI, 8'h00, SrcARs1, SrcBImm, ResAluOut, AluOpRegOp);
    step(OpItypeLogic, 1'b1, 1'b0, StAluWb, RW | RET, SrcAPc, SrcBRs2, ResAluOut, AluOpUnset);

    // LUI then AUIPC
    fetch(OpLui, 1'b1);
    decode(OpLui);
    step(OpLui, 1'b1, 1'b0, StUtype, 8'h00, SrcAZero, SrcBImm, ResAluOut, AluOpAdd);
    step(OpLui, 1'b1, 1'b0, StAluWb, RW | RET, SrcAPc, SrcBRs2, ResAluOut, AluOpUnset);
    fetch(OpAuipc, 1'b1);
    decode(OpAuipc);
    step(OpAuipc, 1'b1, 1'b0, StUtype, 8'h00, SrcAOldPc, SrcBImm, ResAluOut, AluOpAdd);
    step(OpAuipc, 1'b1, 1'b0, StAluWb, RW | RET, SrcAPc, SrcBRs2, ResAluOut, AluOpUnset);

    // Reset asserted mid-access in MEMREAD
    fetch(OpLoad, 1'b1);
    decode(OpLoad);
    step(OpLoad, 1'b1, 1'b0, StMemAdr, 8'h00, SrcARs1, SrcBImm, ResAluOut, AluOpAdd);
    step(OpLoad, 1'b0, 1'b0, StMemRead, MREQ | ADR, SrcAPc, SrcBRs2, ResAluOut, AluOpUnset);
    reset_pulse();

    // Illegal opcode traps until reset
    fetch(opcode_t'(7'b0000000), 1'b1);
    decode(opcode_t'(7'b0000000));
    for (int i = 0; i < 10; i++) begin
      step(opcode_t'(7'b0000000), 1'b1, 1'b1, StTrap, ILL, SrcAPc, SrcBRs2, ResAluOut,
           AluOpUnset);
    end
    reset_pulse();
    fetch(OpRtype, 1'b1);
    decode(OpRtype);

    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
